// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int DEFAULT_TIMEOUT = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req     requester valid bits
//   last    index of the requester served most recently
//   valid   at least one requester is asserting req
//   onehot  one-hot select of the winner
//   idx     binary index of the winner
//
// The search starts at last+1 and wraps, so the most recently served
// requester is examined last.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    output logic          valid,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx
);

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(last) + k) % N;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                onehot = N'(1) << j;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-low reset
//   REQ        per-requester data valid
//   DATA_IN    flattened requester data, requester i at [i*WIDTH +: WIDTH]
//   ACK        per-requester word-accepted strobe (combinational)
//   GNT        registered one-hot grant, zero when idle
//   FIFO_DATA  data to FIFO (muxed from granted requester)
//   FIFO_WE    write enable to FIFO (combinational)
//   FIFO_FULL  FIFO full flag
//
// Build option: FIFO_WR_ARB_TIMEOUT_EN adds a stall counter that releases
// the grant after TIMEOUT consecutive FULL-stalled cycles.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_BITS  = 2,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA_IN,
    output logic [N_REQ-1:0]       ACK,
    output logic [N_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]       FIFO_DATA,
    output logic                   FIFO_WE,
    input  logic                   FIFO_FULL
);

    localparam int PW = ptr_w(N_REQ);

    state_t              state, state_nxt;
    logic [N_REQ-1:0]    gnt, gnt_nxt;
    logic [PW-1:0]       gidx, gidx_nxt;
    logic [PW-1:0]       last, last_nxt;
    logic [CNT_BITS-1:0] count, count_nxt;

    logic                pick_valid;
    logic [N_REQ-1:0]    pick_onehot;
    logic [PW-1:0]       pick_idx;

    logic                req_g;
    logic                wr;
    logic                end_burst;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT) + 1;
    logic [SW-1:0]       stall, stall_nxt;
`endif

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req    (REQ),
        .last   (last),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // gnt is zero outside BURST, so masking with it both selects the
    // granted requester and forces everything off while idle or in reset.
    assign req_g     = |(REQ & gnt);
    assign wr        = (state == ST_BURST) && req_g && !FIFO_FULL;
    assign FIFO_WE   = wr;
    assign ACK       = wr ? gnt : '0;
    assign GNT       = gnt;

    always_comb begin
        FIFO_DATA = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                FIFO_DATA = DATA_IN[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        gidx_nxt  = gidx;
        last_nxt  = last;
        count_nxt = count;
        end_burst = 1'b0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        stall_nxt = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_BURST;
                    gnt_nxt   = pick_onehot;
                    gidx_nxt  = pick_idx;
                    count_nxt = '0;
                end
            end
            ST_BURST: begin
                if (wr) begin
                    if (count == CNT_BITS'(BURST_LEN - 1)) begin
                        end_burst = 1'b1;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end else if (!req_g) begin
                    end_burst = 1'b1;
                end else begin
                    // Requester is waiting on FULL: count and grant hold.
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                    if (stall == SW'(TIMEOUT - 1)) begin
                        end_burst = 1'b1;
                    end else begin
                        stall_nxt = stall + 1'b1;
                    end
`endif
                end
                if (end_burst) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                    last_nxt  = gidx;
                    count_nxt = '0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                    stall_nxt = '0;
`endif
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
            gnt   <= '0;
            gidx  <= '0;
            last  <= PW'(N_REQ - 1);
            count <= '0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            stall <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            gidx  <= gidx_nxt;
            last  <= last_nxt;
            count <= count_nxt;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            stall <= stall_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           CLK;
    logic           RESET;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] DATA_IN;
    logic [N-1:0]   ACK;
    logic [N-1:0]   GNT;
    logic [W-1:0]   FIFO_DATA;
    logic           FIFO_WE;
    logic           FIFO_FULL;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .BURST_LEN (4),
        .CNT_BITS  (2),
        .TIMEOUT   (16)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .DATA_IN   (DATA_IN),
        .ACK       (ACK),
        .GNT       (GNT),
        .FIFO_DATA (FIFO_DATA),
        .FIFO_WE   (FIFO_WE),
        .FIFO_FULL (FIFO_FULL)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] src_q[N][$];
    logic [N-1:0] ack_s;
    int           ack_cnt[N];
    int           n_checks;
    int           n_fail;
    int           cyc;
    int           first_we;
    int           last_we;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void drive_inputs();
        for (int i = 0; i < N; i++) begin
            REQ[i] = (src_q[i].size() != 0);
            DATA_IN[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endfunction

    function automatic void load(input int idx, input logic [W-1:0] d, input bit expect_it);
        exp_t e;
        src_q[idx].push_back(d);
        if (expect_it) begin
            e.idx  = idx;
            e.data = d;
            exp_q.push_back(e);
        end
    endfunction

    // Producers advance to their next word after an accepted cycle.
    always @(posedge CLK) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_s[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        drive_inputs();
    end

    // Monitor: pops the scoreboard on every FIFO write.
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        ack_s = ACK;
        if (FIFO_WE) begin
            check("we_while_full", {31'b0, FIFO_FULL}, 32'd0);
            for (int i = 0; i < N; i++) if (ACK[i]) ack_cnt[i]++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'b0, FIFO_DATA}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", {24'b0, FIFO_DATA}, {24'b0, e.data});
                check("wr_ack", {28'b0, ACK}, 32'(1) << e.idx);
                check("wr_gnt", {28'b0, GNT}, 32'(1) << e.idx);
            end
        end else begin
            check("ack_without_we", {28'b0, ACK}, 32'd0);
        end
    end

    task automatic wait_drain(input int max);
        for (int k = 0; k < max && exp_q.size() != 0; k++) @(negedge CLK);
        check("drain", exp_q.size(), 32'd0);
        repeat (3) @(negedge CLK);
    endtask

    int base[N];

    task automatic snap();
        for (int i = 0; i < N; i++) base[i] = ack_cnt[i];
    endtask

    initial begin
        int k;
        n_checks = 0; n_fail = 0; cyc = 0; first_we = -1; last_we = -1;
        ack_s = '0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        RESET = 1'b0;
        FIFO_FULL = 1'b0;

        // 1/3: all four requesters loaded while reset held; rotation 0,1,2,3,0.
        for (int j = 0; j < 8; j++) load(0, W'(j), 1'b0);
        for (int j = 0; j < 4; j++) load(1, W'(8'h10 + j), 1'b0);
        for (int j = 0; j < 4; j++) load(2, W'(8'h20 + j), 1'b0);
        for (int j = 0; j < 4; j++) load(3, W'(8'h30 + j), 1'b0);
        begin
            exp_t e;
            int order[5] = '{0, 1, 2, 3, 0};
            for (int b = 0; b < 5; b++)
                for (int j = 0; j < 4; j++) begin
                    e.idx  = order[b];
                    e.data = (order[b] == 0) ? W'((b == 0 ? 0 : 4) + j) : W'(8'h10 * order[b] + j);
                    exp_q.push_back(e);
                end
        end
        drive_inputs();
        repeat (5) begin
            @(negedge CLK);
            check("rst_gnt", {28'b0, GNT}, 32'd0);
            check("rst_we", {31'b0, FIFO_WE}, 32'd0);
        end
        @(posedge CLK); #2;
        RESET = 1'b1;
        snap();
        for (k = 0; k < 10 && GNT == '0; k++) @(negedge CLK);
        check("first_gnt", {28'b0, GNT}, 32'h1);
        wait_drain(200);
        check("rr_cycles", last_we - first_we + 1, 32'd24);
        check("rr_cnt0", ack_cnt[0] - base[0], 32'd8);
        check("rr_cnt1", ack_cnt[1] - base[1], 32'd4);
        check("rr_cnt3", ack_cnt[3] - base[3], 32'd4);

        // 2: requester 2 alone, three words then REQ drops.
        @(posedge CLK); #2;
        snap();
        load(2, 8'h11, 1'b1); load(2, 8'h22, 1'b1); load(2, 8'h33, 1'b1);
        drive_inputs();
        @(negedge CLK);
        check("t2_gnt_lat0", {28'b0, GNT}, 32'd0);
        @(negedge CLK);
        check("t2_gnt", {28'b0, GNT}, 32'h4);
        wait_drain(50);
        check("t2_ack2", ack_cnt[2] - base[2], 32'd3);
        check("t2_idle", {28'b0, GNT}, 32'd0);

        // 4: requester 1 stalled by FULL for 3 cycles after its 2nd word.
        @(posedge CLK); #2;
        snap();
        for (int j = 0; j < 4; j++) load(1, W'(8'hA0 + j), 1'b1);
        drive_inputs();
        repeat (3) begin @(posedge CLK); #2; end
        FIFO_FULL = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("t4_we_stall", {31'b0, FIFO_WE}, 32'd0);
            check("t4_gnt_stall", {28'b0, GNT}, 32'h2);
        end
        @(posedge CLK); #2;
        FIFO_FULL = 1'b0;
        wait_drain(50);
        check("t4_ack1", ack_cnt[1] - base[1], 32'd4);

        // 5: reset in the middle of requester 3's burst.
        @(posedge CLK); #2;
        load(3, 8'hC0, 1'b1); load(3, 8'hC1, 1'b1);
        load(3, 8'hC2, 1'b0); load(3, 8'hC3, 1'b0);
        drive_inputs();
        repeat (3) begin @(posedge CLK); #2; end
        RESET = 1'b0;
        #1;
        check("t5_async_gnt", {28'b0, GNT}, 32'd0);
        check("t5_async_we", {31'b0, FIFO_WE}, 32'd0);
        check("t5_async_ack", {28'b0, ACK}, 32'd0);
        src_q[3].delete();
        for (int i = 0; i < N; i++) load(i, W'(8'hE0 + i), 1'b1);
        drive_inputs();
        @(negedge CLK);
        check("t5_rst_we", {31'b0, FIFO_WE}, 32'd0);
        @(posedge CLK); #2;
        RESET = 1'b1;
        for (k = 0; k < 10 && GNT == '0; k++) @(negedge CLK);
        check("t5_first_gnt", {28'b0, GNT}, 32'h1);
        wait_drain(100);

        // 6: requester 0 held off by FULL.
        @(posedge CLK); #2;
        FIFO_FULL = 1'b1;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        load(0, 8'h5A, 1'b0); load(1, 8'h6B, 1'b1); load(0, 8'h5A, 1'b1);
        void'(src_q[0].pop_back());
`else
        load(0, 8'h5A, 1'b1); load(1, 8'h6B, 1'b1);
`endif
        drive_inputs();
        @(negedge CLK);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        repeat (16) begin
            @(negedge CLK);
            check("t6_hold", {28'b0, GNT}, 32'h1);
        end
        @(negedge CLK);
        check("t6_release", {28'b0, GNT}, 32'd0);
        @(negedge CLK);
        check("t6_next", {28'b0, GNT}, 32'h2);
`else
        repeat (40) begin
            @(negedge CLK);
            check("t6_hold", {28'b0, GNT}, 32'h1);
        end
`endif
        @(posedge CLK); #2;
        FIFO_FULL = 1'b0;
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
